pipe_elastic_reg: RTL and testbench
===================================

# pipe_elastic_reg

Parametrised elastic pipeline stage that replaces the fixed enable/flush stage register between pipeline stages. It holds up to DEPTH entries in a circular skid buffer, so upstream can keep issuing for DEPTH cycles after downstream stalls. It uses a valid/ready handshake on both sides and a synchronous flush that drops every entry. A stall no longer loses or freezes data, and a flush empties the stage completely.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- DEPTH, 2: number of buffer entries; power of two, 2..16.
- CW, $clog2(DEPTH+1): width of the occupancy output (derived; do not override).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream takes head this cycle.
- out_data  out  WIDTH  head entry payload.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH×WIDTH register array, wr_ptr and rd_ptr of log2(DEPTH) bits, count register of CW bits. Pointers wrap modulo DEPTH naturally. There is no extra wrap bit; full/empty come only from count.
- Push: occurs when in_valid && in_ready. Writes mem[wr_ptr] and increments wr_ptr.
- Pop: occurs when out_valid && out_ready. Increments rd_ptr.
- count update: count += push − pop. A simultaneous push and pop leaves count unchanged.
- in_ready = rst && (count != DEPTH).
  - in_ready does not depend on out_ready; there is no combinational path from out_ready to in_ready.
  - When full, a push is refused even if out_ready=1 in the same cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid, otherwise all zeros. The mask is mandatory so an idle stage presents 0, matching the bubble value of the old stage register.
- Flush (flush=1 at a rising edge):
  - count, wr_ptr and rd_ptr go to 0.
  - Any push or pop handshake in that cycle is discarded; the upstream beat offered in that cycle is lost, and downstream must ignore a head seen in that cycle.
  - The array contents need not be cleared.
- Reset (rst=0, asynchronous): count, wr_ptr and rd_ptr go to 0 immediately.
- Ordering: strict FIFO; no entry is ever dropped or duplicated outside flush and reset.

## Timing
- Reset values: out_valid=0, out_data=0, count=0, in_ready=0 while rst=0, and in_ready=1 from the first cycle after release.
- Latency: a beat pushed at edge N appears on out_valid/out_data after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: 1 beat/cycle sustained when out_ready=1 continuously and count<DEPTH.
- Stall: with out_ready=0, the stage accepts exactly DEPTH more beats, then drops in_ready in the cycle after count reaches DEPTH.
- Full with out_ready=1:
  - The pop happens at that edge; count becomes DEPTH−1.
  - in_ready rises in the following cycle. This gives a one-cycle bubble, which is required.
- Flush has effect at the edge where it is sampled. The next cycle shows out_valid=0, count=0, in_ready=1.
- Reset asserted mid-operation clears state within the same cycle without waiting for a clock. All in-flight data is discarded.

## Test plan
- Reset: hold rst=0 with in_valid=1 and in_data=0xA5A5A5A5 -> in_ready=0, out_valid=0, out_data=0, count=0. After release, in_ready=1 and nothing appears until a push.
- Streaming: out_ready=1, push 0x1..0x20 on consecutive cycles -> each value appears one cycle after its push, in order; count stays 1; in_ready stays 1 throughout.
- Stall/fill with DEPTH=4:
  - Hold out_ready=0 and push 0x10..0x13 -> count reaches 4 and in_ready=0.
  - A fifth beat 0x14 is held upstream.
  - Release out_ready -> outputs 0x10..0x14 in order, with the 1-cycle bubble before 0x14 is accepted.
- Wrap-around: DEPTH=4, randomised in_valid/out_ready over 1000 cycles -> scoreboard matches exactly, pointers wrap past 3, and count never exceeds 4 or goes below 0.
- Flush:
  - Fill with 3 entries, then assert flush for one cycle with in_valid=1 (data 0x77) and out_ready=1.
  - Next cycle: count=0, out_valid=0, out_data=0.
  - 0x77 is not stored, and the next pushed beat is the first output.
- Async reset mid-stream: with count=2, pull rst low between clock edges -> out_valid, count and in_ready drop to 0 before the next edge. After release, the stage behaves as freshly reset.

Source files
------------

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: elastic pipeline stage built around a small circular skid buffer.
// Upstream may keep issuing for DEPTH beats after downstream stalls; flush drops every
// entry at the sampling edge, and the asynchronous active-low reset clears the stage
// without waiting for a clock.
module pipe_elastic_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    // Pointer width; DEPTH is a power of two, so pointers wrap on their own.
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [CW-1:0]    push_ext;
    logic [CW-1:0]    pop_ext;

    // Full and empty come only from the occupancy counter. in_ready looks only at
    // count, never at out_ready, so a full stage refuses a beat even while it is
    // draining, which produces the required one-cycle bubble.
    assign in_ready  = rst && (count != FULL);
    assign out_valid = (count != '0);

    // A flush cancels whatever handshakes happen in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign push_ext = {{(CW-1){1'b0}}, push};
    assign pop_ext  = {{(CW-1){1'b0}}, pop};

    // An idle stage presents zero so it looks like a bubble to downstream logic.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // Payload storage is not reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + push_ext - pop_ext;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb_pipe_elastic_reg: randomized and directed checks of pipe_elastic_reg (DEPTH=4)
// against a queue-based model of the stage's FIFO behaviour.
module tb_pipe_elastic_reg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int tests = 0;
    int fails = 0;

    // Model: the stage contents as a plain queue, head at index 0.
    logic [WIDTH-1:0] model_q[$];

    pipe_elastic_reg #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against what the model says the stage must show.
    task automatic checkOutput();
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic             exp_ready;
        exp_valid = (model_q.size() != 0);
        exp_data  = exp_valid ? model_q[0] : '0;
        exp_ready = rst && (model_q.size() < DEPTH);
        checkVal("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        checkVal("out_data", out_data, exp_data);
        checkVal("count", {{(32-CW){1'b0}}, count}, model_q.size());
        checkVal("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    endtask

    // Advance the model by one rising edge from the inputs the bench is driving.
    task automatic modelEdge();
        bit can_push;
        bit can_pop;
        if (!rst || flush) begin
            model_q.delete();
        end else begin
            can_push = in_valid && (model_q.size() < DEPTH);
            can_pop  = out_ready && (model_q.size() > 0);
            if (can_pop)  void'(model_q.pop_front());
            if (can_push) model_q.push_back(in_data);
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, check at the falling edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        // Reset held with a beat offered: nothing is accepted or shown.
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        checkVal("reset_in_ready", {31'b0, in_ready}, 32'd0);
        checkVal("reset_out_data", out_data, 32'd0);
        rst = 1'b1;
        #1;
        checkVal("release_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkVal("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Streaming with downstream always ready: each beat appears one cycle later.
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
            if (i == 1) checkVal("stream_first", out_data, 32'h1);
        end
        checkVal("stream_count", {{(32-CW){1'b0}}, count}, 32'd1);
        checkVal("stream_last", out_data, 32'h20);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall and fill: four beats accepted, the fifth held upstream.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h10 + i, 1'b0, 1'b0);
        checkVal("fill_count", {{(32-CW){1'b0}}, count}, 32'd4);
        checkVal("fill_in_ready", {31'b0, in_ready}, 32'd0);
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b1, 1'b0);
        checkVal("bubble_count", {{(32-CW){1'b0}}, count}, 32'd3);
        checkVal("bubble_head", out_data, 32'h11);
        applyStimulus(1'b1, 32'h14, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkVal("drain_empty", {31'b0, out_valid}, 32'd0);

        // Randomized traffic with occasional flushes; pointers wrap many times.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with three entries and both handshakes offered.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h50 + i, 1'b0, 1'b0);
        checkVal("preflush_count", {{(32-CW){1'b0}}, count}, 32'd3);
        applyStimulus(1'b1, 32'h77, 1'b1, 1'b1);
        checkVal("flush_count", {{(32-CW){1'b0}}, count}, 32'd0);
        checkVal("flush_out_data", out_data, 32'd0);
        checkVal("flush_in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'h88, 1'b0, 1'b0);
        checkVal("postflush_head", out_data, 32'h88);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries held.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h60 + i, 1'b0, 1'b0);
        checkVal("prereset_count", {{(32-CW){1'b0}}, count}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        model_q.delete();
        checkVal("async_out_valid", {31'b0, out_valid}, 32'd0);
        checkVal("async_count", {{(32-CW){1'b0}}, count}, 32'd0);
        checkVal("async_in_ready", {31'b0, in_ready}, 32'd0);
        checkVal("async_out_data", out_data, 32'd0);
        applyStimulus(1'b1, 32'h99, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput();
        applyStimulus(1'b1, 32'hC3, 1'b0, 1'b0);
        checkVal("after_reset_head", out_data, 32'hC3);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
